// File: rtl/regfile_cmd_driver_if.sv
// regfile_cmd_driver_if
//   Command / response channel bundle for regfile_cmd_driver.
//   Command channel (valid/ready): cmd_valid, cmd_ready, cmd_op[1:0], cmd_data[14:0]
//   Response channel (valid/ready): rsp_valid, rsp_ready, rsp_data[31:0]
//   master: the command source (UART/ROM sequencer, testbench)
//   slave : the driver itself
interface regfile_cmd_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [14:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regfile_cmd_driver.sv
// regfile_cmd_driver
//   Turns abstract register-file commands into the timed switch/button
//   sequences expected by regfile_top, and reads a 32-bit register back by
//   sampling both halves of the LED display.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bus          command/response channels (slave side)
//   sw[15:0]     switch drive to regfile_top
//   btnl         address-load button
//   btnc         execute/write button
//   btnd         upper-half display select
//   btnu         register-file reset button
//   led[15:0]    LED output of regfile_top
//   busy         high whenever the driver is not idle
// Optional feature: define REGFILE_CMD_DRIVER_RESET_EN to pulse btnu for one
//   cycle after reset release, followed by a GAP_CYCLES settle period.
module regfile_cmd_driver #(
    parameter int SETUP_CYCLES  = 2,
    parameter int PRESS_CYCLES  = 4,
    parameter int GAP_CYCLES    = 10,
    parameter int SAMPLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    regfile_cmd_driver_if.slave         bus,
    output logic [15:0]                 sw,
    output logic                        btnl,
    output logic                        btnc,
    output logic                        btnd,
    output logic                        btnu,
    input  logic [15:0]                 led,
    output logic                        busy
);

    // Zero-length phases are stretched to one cycle so every state is visible.
    localparam int SETUP_EFF  = (SETUP_CYCLES  < 1) ? 1 : SETUP_CYCLES;
    localparam int PRESS_EFF  = (PRESS_CYCLES  < 1) ? 1 : PRESS_CYCLES;
    localparam int GAP_EFF    = (GAP_CYCLES    < 1) ? 1 : GAP_CYCLES;
    localparam int SAMPLE_EFF = (SAMPLE_CYCLES < 1) ? 1 : SAMPLE_CYCLES;

    localparam logic [15:0] SETUP_LD  = 16'(SETUP_EFF - 1);
    localparam logic [15:0] PRESS_LD  = 16'(PRESS_EFF - 1);
    localparam logic [15:0] GAP_LD    = 16'(GAP_EFF - 1);
    localparam logic [15:0] SAMPLE_LD = 16'(SAMPLE_EFF - 1);

    localparam logic [1:0] OP_SET_ADDR  = 2'd0;
    localparam logic [1:0] OP_WRITE_IMM = 2'd1;
    localparam logic [1:0] OP_ALU       = 2'd2;
    localparam logic [1:0] OP_READ      = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        PRESS,
        GAP,
        READ_LO,
        READ_HI,
`ifdef REGFILE_CMD_DRIVER_RESET_EN
        RST_PULSE,
        RST_WAIT,
`endif
        RESP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;
    logic [15:0] cnt_d;
    logic [1:0]  op;
    logic        accept;
    logic        capture_lo;
    logic        capture_hi;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign busy          = (state != IDLE);

    // Next-state and phase-timer logic. The counter is reloaded with the
    // duration of the state being entered and counts down to zero.
    always_comb begin
        next_state = state;
        cnt_d      = (cnt == 16'd0) ? 16'd0 : cnt - 16'd1;
        accept     = 1'b0;
        capture_lo = 1'b0;
        capture_hi = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept = 1'b1;
                    if (bus.cmd_op == OP_READ) begin
                        next_state = READ_LO;
                        cnt_d      = SAMPLE_LD;
                    end else begin
                        next_state = SETUP;
                        cnt_d      = SETUP_LD;
                    end
                end
            end
            SETUP: if (cnt == 16'd0) begin
                next_state = PRESS;
                cnt_d      = PRESS_LD;
            end
            PRESS: if (cnt == 16'd0) begin
                next_state = GAP;
                cnt_d      = GAP_LD;
            end
            GAP: if (cnt == 16'd0) next_state = IDLE;
            READ_LO: if (cnt == 16'd0) begin
                capture_lo = 1'b1;
                next_state = READ_HI;
                cnt_d      = SAMPLE_LD;
            end
            READ_HI: if (cnt == 16'd0) begin
                capture_hi = 1'b1;
                next_state = RESP;
            end
            RESP: if (bus.rsp_ready) next_state = IDLE;
`ifdef REGFILE_CMD_DRIVER_RESET_EN
            RST_PULSE: begin
                next_state = RST_WAIT;
                cnt_d      = GAP_LD;
            end
            RST_WAIT: if (cnt == 16'd0) next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    // Buttons are decoded from next_state so they are clean registered
    // outputs aligned exactly with the PRESS / READ_HI windows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
`ifdef REGFILE_CMD_DRIVER_RESET_EN
            state <= RST_PULSE;
`else
            state <= IDLE;
`endif
            cnt          <= 16'd0;
            sw           <= 16'd0;
            btnl         <= 1'b0;
            btnc         <= 1'b0;
            btnd         <= 1'b0;
            bus.rsp_data <= 32'd0;
        end else begin
            state <= next_state;
            cnt   <= cnt_d;
            btnl  <= (next_state == PRESS) && (op == OP_SET_ADDR);
            btnc  <= (next_state == PRESS) && (op != OP_SET_ADDR);
            btnd  <= (next_state == READ_HI);
            if (accept) begin
                case (bus.cmd_op)
                    OP_SET_ADDR:  sw <= {1'b0, bus.cmd_data};
                    OP_WRITE_IMM: sw <= {1'b1, bus.cmd_data};
                    OP_ALU:       sw <= {12'd0, bus.cmd_data[3:0]};
                    default:      sw <= sw;
                endcase
            end
            if (capture_lo) bus.rsp_data[15:0]  <= led;
            if (capture_hi) bus.rsp_data[31:16] <= led;
        end
    end

    // Latched command opcode; only consulted after an accept, so no reset.
    always_ff @(posedge clk) begin
        if (accept) op <= bus.cmd_op;
    end

`ifdef REGFILE_CMD_DRIVER_RESET_EN
    // btnu is high while reset is applied and for the single RST_PULSE
    // cycle that follows release; a mid-sequence reset restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) btnu <= 1'b1;
        else        btnu <= 1'b0;
    end
`else
    assign btnu = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_cmd_driver.sv
module tb_regfile_cmd_driver;

`ifdef REGFILE_CMD_DRIVER_RESET_EN
    localparam bit RESET_EN = 1'b1;
`else
    localparam bit RESET_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] sw;
    logic        btnl, btnc, btnd, btnu;
    logic [15:0] led;
    logic        busy;
    logic [15:0] led_lo, led_hi;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_q[$];

    regfile_cmd_driver_if bus();

    regfile_cmd_driver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .sw    (sw),
        .btnl  (btnl),
        .btnc  (btnc),
        .btnd  (btnd),
        .btnu  (btnu),
        .led   (led),
        .busy  (busy)
    );

    // Stand-in for regfile_top's display: lower half when btnd=0, upper when 1.
    assign led = btnd ? led_hi : led_lo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard whenever a response handshake
    // is about to happen on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_rsp: got %0h expected no response", bus.rsp_data);
            end else begin
                check("rsp_data", bus.rsp_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [14:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
`ifdef REGFILE_CMD_DRIVER_RESET_EN
        begin
            int n_busy = 0;
            int n_btnu = 0;
            for (int t = 0; t < 50; t++) begin
                if (bus.cmd_ready) break;
                n_busy++;
                if (btnu) n_btnu++;
                tick();
            end
            check("rst_seq_ready_low_cycles", n_busy, 11);
            check("rst_seq_btnu_cycles", n_btnu, 1);
            check("rst_seq_btnu_after", btnu, 0);
        end
`else
        check("release_cmd_ready", bus.cmd_ready, 1);
        check("release_btnu", btnu, 0);
`endif
    endtask

    // Issue a non-READ command and watch its full button sequence while
    // junk commands are presented on the (ignored) command channel.
    task automatic do_write(input string name, input logic [1:0] op,
                            input logic [14:0] data, input logic [15:0] exp_sw);
        int  first_hi = -1;
        int  n_hi     = 0;
        int  n_other  = 0;
        int  ready_t  = -1;
        bit  overlap  = 0;
        bit  sw_bad   = 0;
        bit  d_seen   = 0;
        bit  is_l;
        is_l = (op == 2'd0);
        send(op, data);
        check({name, "_busy"}, busy, 1);
        for (int t = 0; t < 100; t++) begin
            if (bus.cmd_ready) begin
                ready_t = t;
                break;
            end
            if (sw !== exp_sw) sw_bad = 1;
            if (btnl && btnc) overlap = 1;
            if (btnd) d_seen = 1;
            if (is_l ? btnl : btnc) begin
                if (first_hi < 0) first_hi = t;
                n_hi++;
            end
            if (is_l ? btnc : btnl) n_other++;
            bus.cmd_valid = (t <= 10);
            bus.cmd_op    = 2'(t);
            bus.cmd_data  = 15'h2AAA ^ 15'(t);
            tick();
        end
        bus.cmd_valid = 1'b0;
        check({name, "_sw_held"}, sw_bad, 0);
        check({name, "_sw_final"}, sw, exp_sw);
        check({name, "_press_start"}, first_hi, 2);
        check({name, "_press_len"}, n_hi, 4);
        check({name, "_other_btn"}, n_other, 0);
        check({name, "_btn_overlap"}, overlap, 0);
        check({name, "_btnd"}, d_seen, 0);
        check({name, "_ready_time"}, ready_t, 16);
    endtask

    task automatic do_read(input string name, input logic [15:0] lo,
                           input logic [15:0] hi, input int hold);
        bit          d_bad = 0;
        bit          lc_bad = 0;
        bit          v_early = 0;
        logic [15:0] sw_before;
        sw_before     = sw;
        led_lo        = lo;
        led_hi        = hi;
        exp_q.push_back({hi, lo});
        bus.rsp_ready = (hold == 0);
        send(2'd3, 15'h7123);
        bus.cmd_data  = 15'h0F0F;
        for (int t = 0; t < 8; t++) begin
            if (btnd !== (t >= 4)) d_bad = 1;
            if (btnl || btnc) lc_bad = 1;
            if (bus.rsp_valid) v_early = 1;
            tick();
        end
        check({name, "_btnd_window"}, d_bad, 0);
        check({name, "_no_lc"}, lc_bad, 0);
        check({name, "_rsp_early"}, v_early, 0);
        check({name, "_sw_kept"}, sw, sw_before);
        check({name, "_rsp_valid"}, bus.rsp_valid, 1);
        check({name, "_btnd_resp"}, btnd, 0);
        for (int h = 0; h < hold; h++) begin
            led_lo = ~lo;
            led_hi = ~hi;
            check({name, "_hold_valid"}, bus.rsp_valid, 1);
            check({name, "_hold_data"}, bus.rsp_data, {hi, lo});
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check({name, "_idle_ready"}, bus.cmd_ready, 1);
        check({name, "_idle_valid"}, bus.rsp_valid, 0);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 15'd0;
        bus.rsp_ready = 1'b0;
        led_lo        = 16'h0;
        led_hi        = 16'h0;
        repeat (3) tick();

        check("rst_sw", sw, 16'h0);
        check("rst_btns", {btnl, btnc, btnd}, 3'b000);
        check("rst_btnu", btnu, RESET_EN);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 32'h0);
        check("rst_cmd_ready", bus.cmd_ready, !RESET_EN);
        check("rst_busy", busy, RESET_EN);
        release_reset();

        do_write("set_addr", 2'd0, 15'h0443, 16'h0443);
        do_write("set_addr5", 2'd0, 15'h1405, 16'h1405);
        do_write("write_imm", 2'd1, 15'h7FFF, 16'hFFFF);
        do_read("read_all1", 16'hFFFF, 16'hFFFF, 0);
        do_write("alu_xor", 2'd2, 15'h7FFD, 16'h000D);
        do_read("read_hold", 16'h1234, 16'hABCD, 5);

        // Reset in the middle of a WRITE_IMM press.
        send(2'd1, 15'h0055);
        tick();
        tick();
        check("midrst_press_btnc", btnc, 1);
        check("midrst_press_sw", sw, 16'h8055);
        rst_n = 1'b0;
        tick();
        check("midrst_btnc", btnc, 0);
        check("midrst_sw", sw, 16'h0);
        check("midrst_cmd_ready", bus.cmd_ready, !RESET_EN);
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_rsp_data", bus.rsp_data, 32'h0);
        tick();
        release_reset();
        begin
            bit v_seen = 0;
            for (int t = 0; t < 5; t++) begin
                if (bus.rsp_valid || btnc || btnl) v_seen = 1;
                tick();
            end
            check("post_rst_quiet", v_seen, 0);
        end

        check("pending_rsp", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_cmd_driver.md
Name: regfile_cmd_driver

Overview:
- Command-side initiator for the lab-3 register-file top level.
- Accepts abstract commands over a valid/ready handshake and produces the timed switch/button sequences that `regfile_top` expects on `sw`, `btnl`, `btnc`, `btnd` and `btnu`.
- For READ commands it samples `led` in both halves and returns the 32-bit register value.
- Drives the register file from a UART/ROM command source, replacing hand-pressed buttons.

Parameters:
- SETUP_CYCLES, 2: cycles `sw` is held stable before a button press (min 1; 0 treated as 1).
- PRESS_CYCLES, 4: cycles a button is held high (min 1).
- GAP_CYCLES, 10: idle cycles after button release before the next command (min 1).
- SAMPLE_CYCLES, 4: cycles per read half before `led` is captured (min 1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  driver can accept a command
- cmd_op  input  2  0=SET_ADDR, 1=WRITE_IMM, 2=ALU, 3=READ
- cmd_data  input  15  SET_ADDR: {rd,rs2,rs1}; WRITE_IMM: 15-bit immediate; ALU: [3:0] op code; READ: ignored
- rsp_valid  output  1  read result available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  32  {upper led half, lower led half}
- sw  output  16  switch drive to register-file top
- btnl  output  1  address-load button
- btnc  output  1  execute/write button
- btnd  output  1  upper-half display select
- btnu  output  1  register-file reset button
- led  input  16  register-file LED output
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0 at an edge):
  - Next state is IDLE.
  - sw=0, btnl=btnc=btnd=btnu=0, rsp_valid=0, rsp_data=0, cmd_ready=1, busy=0.
  - Applies mid-operation with no partial response; a held button drops the cycle after the reset edge.
- States: IDLE, SETUP, PRESS, GAP, READ_LO, READ_HI, RESP. A single down-counter times each state.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid & cmd_ready at an edge) registers op and data.
  - READ goes to READ_LO. All other ops go to SETUP.
- sw value loaded on accept, held until the next accept:
  - SET_ADDR: {1'b0, cmd_data}.
  - WRITE_IMM: {1'b1, cmd_data}.
  - ALU: {12'b0, cmd_data[3:0]}.
  - READ: sw unchanged.
- SETUP: lasts SETUP_CYCLES cycles, all buttons low.
- PRESS: lasts PRESS_CYCLES cycles.
  - SET_ADDR drives btnl=1.
  - WRITE_IMM and ALU drive btnc=1.
  - Buttons are registered outputs, high exactly PRESS_CYCLES consecutive cycles.
- GAP: lasts GAP_CYCLES cycles, buttons low, then IDLE.
  - cmd_ready rises exactly SETUP_CYCLES+PRESS_CYCLES+GAP_CYCLES cycles after the accept edge.
- READ_LO: btnd=0 for SAMPLE_CYCLES cycles. led is captured into rsp_data[15:0] at the final edge.
- READ_HI: btnd=1 for SAMPLE_CYCLES cycles. led is captured into rsp_data[31:16] at the final edge.
- RESP:
  - btnd=0 and rsp_valid=1.
  - rsp_data is held stable until rsp_valid & rsp_ready at an edge, then IDLE.
  - rsp_ready already high on entry means a one-cycle RESP.
- cmd_ready=0 in every state but IDLE. cmd_valid outside IDLE is ignored and not queued.
- btnl and btnc are never high simultaneously. btnd is high only in READ_HI.
- cmd_op/cmd_data changes after accept have no effect.

Optional Feature:
- Macro: REGFILE_CMD_DRIVER_RESET_EN.
- Defined:
  - After rst_n deasserts, the driver enters a RST_PULSE state that drives btnu=1 for 1 cycle.
  - It then waits GAP_CYCLES cycles with btnu=0, then enters IDLE.
  - cmd_ready and busy follow state (cmd_ready=0, busy=1) during this sequence.
  - rst_n=0 mid-sequence restarts it.
- Undefined: btnu is tied to 0 and the driver enters IDLE directly from reset.

Test Plan:
- Reset then SET_ADDR with cmd_data=0x0443 (rd=1, rs2=2, rs1=3):
  - sw=0x0443 from the cycle after accept.
  - btnl high exactly 4 cycles starting 2 cycles after SETUP entry.
  - cmd_ready returns 16 cycles after accept.
- WRITE_IMM 0x7FFF after SET_ADDR rd=5: sw=0xFFFF, btnc high 4 cycles. A following READ of rs1=5 against the real `regfile_top` returns rsp_data=0xFFFFFFFF.
- ALU op 0xD (XOR) with cmd_data=0x7FFD: sw=0x000D (upper data bits discarded), btnc pulse of 4 cycles, btnl stays 0.
- READ with led model returning 0x1234 when btnd=0 and 0xABCD when btnd=1, rsp_ready held low 5 cycles: rsp_data=0xABCD1234, rsp_valid held stable 5 cycles, then IDLE.
- rst_n=0 during PRESS of a WRITE_IMM: btnc=0 and sw=0 the cycle after the reset edge, cmd_ready=1, no rsp_valid.
- With REGFILE_CMD_DRIVER_RESET_EN defined: after rst_n release, btnu=1 for exactly 1 cycle, cmd_ready=0 for 11 cycles, then 1.
